cr_ahbl_req_arb: RTL

//  Two-master request arbiter that sits directly upstream of the AHB-Lite bus interface unit.

---
 rtl/cr_ahbl_req_arb.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/cr_ahbl_req_arb.sv
// cr_ahbl_req_arb: IFU/LSU request arbiter in front of the AHB-Lite
// interface unit; owns the single outstanding data phase and its routing.
module cr_ahbl_req_arb #(
  parameter int DATA_WIDTH = 32,
  parameter bit RR_EN      = 1'b1
) (
  input  logic                  ahbl_gated_clk,
  input  logic                  cpurst_b,
  input  logic                  ifu_req,
  input  logic [DATA_WIDTH-1:0] ifu_addr,
  input  logic [3:0]            ifu_prot,
  input  logic                  ifu_vec,
  output logic                  ifu_grnt,
  output logic                  ifu_data_vld,
  output logic                  ifu_acc_err,
  input  logic                  lsu_req,
  input  logic [DATA_WIDTH-1:0] lsu_addr,
  input  logic                  lsu_write,
  input  logic [1:0]            lsu_size,
  input  logic [3:0]            lsu_prot,
  input  logic [DATA_WIDTH-1:0] lsu_wdata,
  output logic                  lsu_grnt,
  output logic                  lsu_trans_cmplt,
  output logic                  lsu_data_vld,
  output logic                  lsu_acc_err,
  output logic [DATA_WIDTH-1:0] bus_rdata,
  output logic                  cpu_req,
  output logic [DATA_WIDTH-1:0] cpu_addr,
  output logic                  cpu_write,
  output logic [1:0]            cpu_size,
  output logic [3:0]            cpu_prot,
  output logic                  cpu_vec_redirect,
  output logic [DATA_WIDTH-1:0] cpu_wr_data,
  input  logic                  cpu_req_grnt,
  input  logic                  cpu_trans_cmplt,
  input  logic                  cpu_data_vld,
  input  logic                  cpu_acc_err,
  input  logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  arb_idle
);

  logic                  sel_lock_q, sel_lock_d;
  logic                  lock_owner_q, lock_owner_d;
  logic                  rr_last_q, rr_last_d;
  logic                  dp_vld_q, dp_vld_d;
  logic                  dp_owner_q, dp_owner_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  sel;
  logic                  grant;

  // sel: 0 = IFU, 1 = LSU
  always_comb begin
    sel = 1'b0;
    if (sel_lock_q) begin
      sel = lock_owner_q;
    end else if (ifu_req && lsu_req) begin
      sel = RR_EN ? ~rr_last_q : 1'b1;
    end else begin
      sel = lsu_req;
    end
  end

  assign cpu_req = sel ? lsu_req : ifu_req;
  assign grant   = cpu_req_grnt;

  always_comb begin
    cpu_addr         = '0;
    cpu_write        = 1'b0;
    cpu_size         = 2'd0;
    cpu_prot         = 4'd0;
    cpu_vec_redirect = 1'b0;
    if (cpu_req) begin
      if (sel) begin
        cpu_addr  = lsu_addr;
        cpu_write = lsu_write;
        cpu_size  = lsu_size;
        cpu_prot  = lsu_prot;
      end else begin
        cpu_addr         = ifu_addr;
        cpu_size         = 2'd2;
        cpu_prot         = ifu_prot;
        cpu_vec_redirect = ifu_vec;
      end
    end
  end

  assign ifu_grnt = grant & ~sel;
  assign lsu_grnt = grant & sel;

  always_comb begin
    sel_lock_d   = cpu_req & ~grant;
    lock_owner_d = lock_owner_q;
    rr_last_d    = rr_last_q;
    dp_vld_d     = dp_vld_q;
    dp_owner_d   = dp_owner_q;
    wdata_d      = wdata_q;
    if (cpu_req && !grant) begin
      lock_owner_d = sel;
    end
    // a grant in the completion cycle keeps the phase valid for the new owner
    if (grant) begin
      rr_last_d  = sel;
      dp_vld_d   = 1'b1;
      dp_owner_d = sel;
      if (sel && lsu_write) begin
        wdata_d = lsu_wdata;
      end
    end else if (cpu_trans_cmplt) begin
      dp_vld_d = 1'b0;
    end
  end

  always_ff @(posedge ahbl_gated_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      sel_lock_q   <= 1'b0;
      lock_owner_q <= 1'b0;
      rr_last_q    <= 1'b0;
      dp_vld_q     <= 1'b0;
      dp_owner_q   <= 1'b0;
      wdata_q      <= '0;
    end else begin
      sel_lock_q   <= sel_lock_d;
      lock_owner_q <= lock_owner_d;
      rr_last_q    <= rr_last_d;
      dp_vld_q     <= dp_vld_d;
      dp_owner_q   <= dp_owner_d;
      wdata_q      <= wdata_d;
    end
  end

  assign cpu_wr_data     = wdata_q;
  assign bus_rdata       = cpu_rdata;
  assign ifu_data_vld    = cpu_data_vld & dp_vld_q & ~dp_owner_q;
  assign ifu_acc_err     = cpu_acc_err & dp_vld_q & ~dp_owner_q;
  assign lsu_data_vld    = cpu_data_vld & dp_vld_q & dp_owner_q;
  assign lsu_acc_err     = cpu_acc_err & dp_vld_q & dp_owner_q;
  assign lsu_trans_cmplt = cpu_trans_cmplt & dp_vld_q & dp_owner_q;
  assign arb_idle        = ~ifu_req & ~lsu_req & ~dp_vld_q;

endmodule
